seq_alu: RTL

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Generalised to WIDTH bits. Adds iterative unsigned multiply and divide, a valid/ready handshake on both sides, and a divide-by-zero flag.
- Sits in the execute stage. The pipeline holds the instruction while in_ready or out_valid is low.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/iter_muldiv.sv | 68 ++++++
 rtl/seq_alu.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the execute-stage ALU: the extended opcode set and the FSM states.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    SLL  = 4'd0,
    SRL  = 4'd1,
    SRA  = 4'd2,
    ADD  = 4'd3,
    SUB  = 4'd4,
    AND  = 4'd5,
    OR   = 4'd6,
    XOR  = 4'd7,
    NOR  = 4'd8,
    SLT  = 4'd9,
    SLTU = 4'd10,
    MULU = 4'd11,
    DIVU = 4'd12
  } aluop_ext_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_alu_state_t;

  // Opcodes that run through the iterative multiply/divide datapath.
  function automatic logic is_iterative(input logic [3:0] op);
    return (op == MULU) || (op == DIVU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per step.
// {hi, lo} is a single 2*WIDTH shift register: for MULU lo starts as the multiplier
// and ends as the low product; for DIVU lo starts as the dividend and ends as the
// quotient while hi accumulates the partial remainder.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // One iteration of either algorithm, computed from the current register contents.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    sh   = {hi_q, lo_q[WIDTH-1]};
    ge   = (sh >= {1'b0, opnd_q});
    diff = sh[WIDTH-1:0] - opnd_q;
    if (div_q) begin
      nxt_hi = ge ? diff : sh[WIDTH-1:0];
      nxt_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Load operands on accept, advance one iteration per step, otherwise hold.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    if (load) begin
      hi_d   = '0;
      lo_d   = is_div ? a_in : b_in;
      opnd_d = is_div ? b_in : a_in;
      div_d  = is_div;
    end else if (step) begin
      hi_d = nxt_hi;
      lo_d = nxt_lo;
    end
  end

  // Pure datapath registers; the owning FSM decides when their contents matter.
  always_ff @(posedge clk) begin
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
    div_q  <= div_d;
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU with valid/ready on both sides. Single-cycle ops
// complete at the accept edge; MULU/DIVU iterate WIDTH times in iter_muldiv.
module seq_alu
  import cpu_types_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] port_o,
  output logic [WIDTH-1:0] port_hi,
  output logic             neg_flag,
  output logic             of_flag,
  output logic             z_flag,
  output logic             dz_flag
);

  seq_alu_state_t   state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [3:0]       op_q, op_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;

  logic             md_load, md_step;
  logic [WIDTH-1:0] md_hi, md_lo;

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SHAMT_W-1:0]      sh;
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0]        r;
    sh = b[SHAMT_W-1:0];
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      SLL:  r = a << sh;
      SRL:  r = a >> sh;
      SRA:  r = sa >>> sh;
      ADD:  r = a + b;
      SUB:  r = a - b;
      AND:  r = a & b;
      OR:   r = a | b;
      XOR:  r = a ^ b;
      NOR:  r = ~(a | b);
      SLT:  r = (sa < sb) ? WIDTH'(1) : '0;
      SLTU: r = (a < b)   ? WIDTH'(1) : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (CLK),
    .load   (md_load),
    .step   (md_step),
    .is_div (opcode == DIVU),
    .a_in   (port_a),
    .b_in   (port_b),
    .nxt_hi (md_hi),
    .nxt_lo (md_lo)
  );

  // Next-state logic: accept in IDLE, iterate in BUSY, hold results in DONE until taken.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    dz_d     = dz_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    md_load  = 1'b0;
    md_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = opcode;
          a_msb_d = port_a[WIDTH-1];
          b_msb_d = port_b[WIDTH-1];
          dz_d    = 1'b0;
          if (opcode == DIVU && port_b == '0) begin
            // Divide by zero never enters the iteration loop.
            dz_d     = 1'b1;
            res_lo_d = '1;
            res_hi_d = port_a;
            state_d  = DONE;
          end else if (is_iterative(opcode)) begin
            md_load = 1'b1;
            count_d = SHAMT_W'(WIDTH - 1);
            state_d = BUSY;
          end else begin
            res_lo_d = alu_single(opcode, port_a, port_b);
            res_hi_d = '0;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        md_step = 1'b1;
        if (count_q == '0) begin
          res_lo_d = md_lo;
          res_hi_d = md_hi;
          state_d  = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset discards any in-flight operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      dz_q     <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      dz_q     <= dz_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign port_o    = res_lo_q;
  assign port_hi   = res_hi_q;

  // Flags derive from the held results and are only asserted while a result is offered.
  always_comb begin
    logic done, known, r_msb;
    done     = (state_q == DONE);
    known    = (op_q <= DIVU);
    r_msb    = res_lo_q[WIDTH-1];
    neg_flag = done && known && r_msb;
    z_flag   = done && known && (res_lo_q == '0);
    dz_flag  = done && dz_q;
    of_flag  = 1'b0;
    if (done) begin
      case (op_q)
        ADD:     of_flag = (a_msb_q == b_msb_q) && (r_msb != a_msb_q);
        SUB:     of_flag = (a_msb_q != b_msb_q) && (r_msb != a_msb_q);
        MULU:    of_flag = (res_hi_q != '0);
        default: of_flag = 1'b0;
      endcase
    end
  end

endmodule
